alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  ID/EX issue slice that drives the ALU operand/opcode interface (SrcA, SrcB, Operation).
//  Decodes ALUOp/Funct3/Funct7 into the 4-bit ALU opcode and selects RD2 or immediate for SrcB.
//  Registers the result behind a valid/ready handshake with stall and flush support.
//  Sits between the register-file read in ID and the combinational ALU in EX.
// PARAMETERS
//  DATA_WIDTH     32  operand width
//  OPCODE_LENGTH  4   ALU opcode width (encodings below are fixed to 4 bits)
// PORTS
//  clk        in   1           rising-edge clock
//  reset      in   1           synchronous, active-high reset
//  in_valid   in   1           ID holds a valid instruction
//  in_ready   out  1           slice can accept this cycle
//  flush      in   1           kill the registered entry (branch taken / hazard bubble)
//  ALUOp      in   2           00 = load/store add, 01 = branch compare, 10 = R/I arith, 11 = reserved
//  Funct3     in   3           instruction funct3
//  Funct7     in   7           instruction funct7
//  ALUSrc     in   1           1 = SrcB takes ImmG (I-type), 0 = SrcB takes RD2
//  RD1        in   DATA_WIDTH  rs1 read data
//  RD2        in   DATA_WIDTH  rs2 read data
//  ImmG       in   DATA_WIDTH  sign-extended immediate
//  out_valid  out  1           EX-side entry valid
//  out_ready  in   1           EX consumes the entry this cycle
//  SrcA       out  DATA_WIDTH  registered RD1
//  SrcB       out  DATA_WIDTH  registered ALUSrc ? ImmG : RD2
//  Operation  out  4           registered ALU opcode
//  IllegalOp  out  1           registered: decoded encoding unsupported
// BEHAVIOUR
//  - Decode (combinational, registered on accept):
//    ALUOp 00 -> 0010 ADD; ALUOp 01 -> 1000 EQUAL (BEQ); ALUOp 11 -> illegal.
//    ALUOp 10, by Funct3:
//      000 -> 0011 SUB if ALUSrc=0 and Funct7=0100000; 0010 ADD otherwise.
//             Funct7 is ignored when ALUSrc=1 (ADDI).
//      111 -> 0000 AND; 110 -> 0001 OR; 100 -> 0100 XOR.
//      001 -> 0101 SLL, requires Funct7=0000000.
//      101 -> 0110 SRL, requires Funct7=0000000 (SRA is illegal).
//      010, 011 -> illegal.
//    R-type 000 with Funct7 other than 0000000/0100000 -> illegal.
//  - Illegal encodings: Operation=1111 (ALU yields 0), IllegalOp=1, entry still passes as valid.
//  - Handshake:
//    in_ready = !out_valid || out_ready (combinational).
//    accept = in_valid && in_ready.
//    On accept: all outputs load at the next edge; out_valid <= 1. Latency is 1 cycle.
//    If out_valid && out_ready && !in_valid: out_valid <= 0 and data outputs hold their values.
//  - Stall: out_valid && !out_ready -> all registered outputs hold and in_ready=0.
//  - Flush:
//    out_valid <= 0 at the next edge, with priority over accept and over stall.
//    An input offered in the flush cycle is dropped; in_ready still follows the formula above.
//  - Reset (sync, any time incl. mid-stall):
//    out_valid=0, SrcA=0, SrcB=0, Operation=0000, IllegalOp=0, optional counter=0.
//    Reset overrides flush and accept.
// CONFIGURATION
//  ILLEGAL_OP_COUNT_EN defined:
//    adds output IllegalCount [15:0], reset 0.
//    Increments by 1 on each accept of an illegal encoding while flush=0.
//    Saturates at 16'hFFFF.
//  Undefined: IllegalCount port and counter absent; all other behaviour identical.
// TESTING
//  - Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, Operation=0000, SrcA=SrcB=0.
//  - R-type SUB: ALUOp=10, F3=000, F7=0100000, ALUSrc=0, RD1=7, RD2=5, out_ready=1
//    -> next cycle Operation=0011, SrcA=7, SrcB=5, out_valid=1.
//  - ADDI: ALUOp=10, F3=000, F7=0100000, ALUSrc=1, ImmG=32'hFFFFFFFF
//    -> Operation=0010, SrcB=32'hFFFFFFFF, IllegalOp=0.
//  - Stall: out_ready=0 for 3 cycles with new ID data -> outputs frozen and in_ready=0;
//    out_ready=1 -> new entry loads next edge.
//  - Flush during stall, with in_valid=1 -> out_valid=0 next cycle and the offered input is not captured.
//  - Illegal SRA: ALUOp=10, F3=101, F7=0100000 -> Operation=1111, IllegalOp=1.
//    With ILLEGAL_OP_COUNT_EN, 3 such accepts give IllegalCount=3.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: ID-side offer (operands, decode fields, valid/ready, flush)
// and EX-side registered entry (SrcA, SrcB, Operation, IllegalOp, valid/ready).
interface alu_issue_stage_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     flush;
    logic [1:0]               ALUOp;
    logic [2:0]               Funct3;
    logic [6:0]               Funct7;
    logic                     ALUSrc;
    logic [DATA_WIDTH-1:0]    RD1;
    logic [DATA_WIDTH-1:0]    RD2;
    logic [DATA_WIDTH-1:0]    ImmG;

    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic                     IllegalOp;

    // Pipeline environment: offers instructions, consumes entries
    modport master (
        output in_valid, flush, ALUOp, Funct3, Funct7, ALUSrc, RD1, RD2, ImmG, out_ready,
        input  in_ready, out_valid, SrcA, SrcB, Operation, IllegalOp
    );

    // Issue slice
    modport slave (
        input  in_valid, flush, ALUOp, Funct3, Funct7, ALUSrc, RD1, RD2, ImmG, out_ready,
        output in_ready, out_valid, SrcA, SrcB, Operation, IllegalOp
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue slice: decodes ALUOp/Funct3/Funct7 into the ALU opcode, muxes SrcB and
// registers the entry behind valid/ready with stall and flush. Optional ILLEGAL_OP_COUNT_EN.
module alu_issue_stage #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    alu_issue_stage_if.slave    bus
`ifdef ILLEGAL_OP_COUNT_EN
    ,
    output logic [15:0]         IllegalCount
`endif
);
    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [OPCODE_LENGTH-1:0] op_c;
    logic                     illegal_c;
    logic [DATA_WIDTH-1:0]    srcb_c;
    logic                     accept_c;

    // Opcode decode; anything not explicitly legal falls through to OP_ILL
    always_comb begin
        op_c      = OP_ILL;
        illegal_c = 1'b1;
        unique case (bus.ALUOp)
            2'b00: begin
                op_c      = OP_ADD;
                illegal_c = 1'b0;
            end
            2'b01: begin
                op_c      = OP_EQ;
                illegal_c = 1'b0;
            end
            2'b10: begin
                unique case (bus.Funct3)
                    3'b000: begin
                        if (bus.ALUSrc || bus.Funct7 == F7_BASE) begin
                            op_c      = OP_ADD;
                            illegal_c = 1'b0;
                        end else if (bus.Funct7 == F7_ALT) begin
                            op_c      = OP_SUB;
                            illegal_c = 1'b0;
                        end
                    end
                    3'b111: begin
                        op_c      = OP_AND;
                        illegal_c = 1'b0;
                    end
                    3'b110: begin
                        op_c      = OP_OR;
                        illegal_c = 1'b0;
                    end
                    3'b100: begin
                        op_c      = OP_XOR;
                        illegal_c = 1'b0;
                    end
                    3'b001: begin
                        if (bus.Funct7 == F7_BASE) begin
                            op_c      = OP_SLL;
                            illegal_c = 1'b0;
                        end
                    end
                    3'b101: begin
                        if (bus.Funct7 == F7_BASE) begin
                            op_c      = OP_SRL;
                            illegal_c = 1'b0;
                        end
                    end
                    default: begin
                        op_c      = OP_ILL;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            default: begin
                op_c      = OP_ILL;
                illegal_c = 1'b1;
            end
        endcase
    end

    assign srcb_c       = bus.ALUSrc ? bus.ImmG : bus.RD2;
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept_c     = bus.in_valid && bus.in_ready;

    // Entry register: reset > flush > accept > drain; otherwise hold (stall)
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.SrcA      <= '0;
            bus.SrcB      <= '0;
            bus.Operation <= '0;
            bus.IllegalOp <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept_c) begin
            bus.out_valid <= 1'b1;
            bus.SrcA      <= bus.RD1;
            bus.SrcB      <= srcb_c;
            bus.Operation <= op_c;
            bus.IllegalOp <= illegal_c;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef ILLEGAL_OP_COUNT_EN
    // Saturating count of accepted illegal encodings that were not flushed
    always_ff @(posedge clk) begin
        if (reset) begin
            IllegalCount <= '0;
        end else if (accept_c && !bus.flush && illegal_c && IllegalCount != 16'hFFFF) begin
            IllegalCount <= IllegalCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: reset, decode table, stall, flush, mid-stall reset
// and, when ILLEGAL_OP_COUNT_EN is defined, the illegal-encoding counter.
module tb_alu_issue_stage;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_issue_stage_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

`ifdef ILLEGAL_OP_COUNT_EN
    logic [15:0] illegal_count;
`endif

    alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ILLEGAL_OP_COUNT_EN
        ,
        .IllegalCount (illegal_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic src, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm);
        bus.in_valid = 1'b1;
        bus.ALUOp    = aluop;
        bus.Funct3   = f3;
        bus.Funct7   = f7;
        bus.ALUSrc   = src;
        bus.RD1      = rd1;
        bus.RD2      = rd2;
        bus.ImmG     = imm;
    endtask

    // One accepted instruction, then check decoded opcode and illegal flag
    task automatic dec(input string tag, input logic [1:0] aluop, input logic [2:0] f3,
                       input logic [6:0] f7, input logic src, input logic [3:0] exp_op,
                       input logic exp_ill);
        offer(aluop, f3, f7, src, 32'h1, 32'h2, 32'h3);
        bus.out_ready = 1'b1;
        tick();
        check({tag, "_op"},  32'(bus.Operation), 32'(exp_op));
        check({tag, "_ill"}, 32'(bus.IllegalOp), 32'(exp_ill));
        check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        offer(2'b10, 3'b000, 7'b0100000, 1'b0, 32'd7, 32'd5, 32'd9);

        // Reset held two cycles with a valid offer
        tick();
        tick();
        check("rst_vld",  32'(bus.out_valid), 32'd0);
        check("rst_op",   32'(bus.Operation), 32'd0);
        check("rst_srca", bus.SrcA, 32'd0);
        check("rst_srcb", bus.SrcB, 32'd0);
        check("rst_ill",  32'(bus.IllegalOp), 32'd0);
`ifdef ILLEGAL_OP_COUNT_EN
        check("rst_cnt",  32'(illegal_count), 32'd0);
`endif
        reset = 1'b0;

        // R-type SUB
        offer(2'b10, 3'b000, 7'b0100000, 1'b0, 32'd7, 32'd5, 32'd9);
        tick();
        check("sub_op",   32'(bus.Operation), 32'h3);
        check("sub_srca", bus.SrcA, 32'd7);
        check("sub_srcb", bus.SrcB, 32'd5);
        check("sub_vld",  32'(bus.out_valid), 32'd1);

        // ADDI ignores Funct7 and takes ImmG
        offer(2'b10, 3'b000, 7'b0100000, 1'b1, 32'd9, 32'd5, 32'hFFFF_FFFF);
        tick();
        check("addi_op",   32'(bus.Operation), 32'h2);
        check("addi_srcb", bus.SrcB, 32'hFFFF_FFFF);
        check("addi_srca", bus.SrcA, 32'd9);
        check("addi_ill",  32'(bus.IllegalOp), 32'd0);

        // Decode table, back-to-back accepts
        dec("ld",      2'b00, 3'b101, 7'b1111111, 1'b1, 4'b0010, 1'b0);
        dec("beq",     2'b01, 3'b000, 7'b0000000, 1'b0, 4'b1000, 1'b0);
        dec("rsv",     2'b11, 3'b000, 7'b0000000, 1'b0, 4'b1111, 1'b1);
        dec("and",     2'b10, 3'b111, 7'b0000000, 1'b0, 4'b0000, 1'b0);
        dec("or",      2'b10, 3'b110, 7'b0000000, 1'b0, 4'b0001, 1'b0);
        dec("xor",     2'b10, 3'b100, 7'b0000000, 1'b0, 4'b0100, 1'b0);
        dec("sll",     2'b10, 3'b001, 7'b0000000, 1'b0, 4'b0101, 1'b0);
        dec("sll_bad", 2'b10, 3'b001, 7'b0100000, 1'b0, 4'b1111, 1'b1);
        dec("srl",     2'b10, 3'b101, 7'b0000000, 1'b0, 4'b0110, 1'b0);
        dec("slt",     2'b10, 3'b010, 7'b0000000, 1'b0, 4'b1111, 1'b1);
        dec("sltu",    2'b10, 3'b011, 7'b0000000, 1'b0, 4'b1111, 1'b1);
        dec("add",     2'b10, 3'b000, 7'b0000000, 1'b0, 4'b0010, 1'b0);
        dec("r_bad7",  2'b10, 3'b000, 7'b0000001, 1'b0, 4'b1111, 1'b1);
        dec("i_bad7",  2'b10, 3'b000, 7'b0000001, 1'b1, 4'b0010, 1'b0);
        dec("sra",     2'b10, 3'b101, 7'b0100000, 1'b0, 4'b1111, 1'b1);

        // Drain: consumer takes the entry, no new offer
        bus.in_valid = 1'b0;
        tick();
        check("drain_vld",  32'(bus.out_valid), 32'd0);
        check("drain_op",   32'(bus.Operation), 32'hF);
        check("drain_rdy",  32'(bus.in_ready), 32'd1);

        // Load entry A, then stall three cycles while B is offered
        offer(2'b10, 3'b111, 7'b0000000, 1'b0, 32'h11, 32'h12, 32'h0);
        tick();
        check("a_srca", bus.SrcA, 32'h11);
        bus.out_ready = 1'b0;
        offer(2'b10, 3'b110, 7'b0000000, 1'b1, 32'h22, 32'h0, 32'h23);
        #1;
        check("stall_rdy0", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_srca", bus.SrcA, 32'h11);
            check("stall_op",   32'(bus.Operation), 32'h0);
            check("stall_vld",  32'(bus.out_valid), 32'd1);
            check("stall_rdy",  32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("b_srca", bus.SrcA, 32'h22);
        check("b_srcb", bus.SrcB, 32'h23);
        check("b_op",   32'(bus.Operation), 32'h1);

        // Flush during stall drops the offered input
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        offer(2'b00, 3'b000, 7'b0000000, 1'b0, 32'h33, 32'h34, 32'h0);
        tick();
        check("fl_vld",  32'(bus.out_valid), 32'd0);
        check("fl_srca", bus.SrcA, 32'h22);
        // Flush beats an accept that the handshake would allow
        bus.out_ready = 1'b1;
        #1;
        check("fl_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        check("fl2_vld",  32'(bus.out_valid), 32'd0);
        check("fl2_srca", bus.SrcA, 32'h22);
        check("fl2_op",   32'(bus.Operation), 32'h1);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("postfl_vld", 32'(bus.out_valid), 32'd0);

        // Reset during a stall
        offer(2'b10, 3'b100, 7'b0000000, 1'b0, 32'h44, 32'h45, 32'h0);
        tick();
        check("pre_rst_srca", bus.SrcA, 32'h44);
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        tick();
        check("mrst_vld",  32'(bus.out_valid), 32'd0);
        check("mrst_srca", bus.SrcA, 32'd0);
        check("mrst_op",   32'(bus.Operation), 32'd0);
        reset         = 1'b0;
        bus.out_ready = 1'b1;

        // Three accepted SRA encodings, then one killed by flush
        for (int i = 0; i < 3; i++) begin
            dec("sra_n", 2'b10, 3'b101, 7'b0100000, 1'b0, 4'b1111, 1'b1);
        end
`ifdef ILLEGAL_OP_COUNT_EN
        check("cnt3", 32'(illegal_count), 32'd3);
`endif
        bus.flush = 1'b1;
        offer(2'b10, 3'b101, 7'b0100000, 1'b0, 32'h1, 32'h2, 32'h3);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("sra_fl_vld", 32'(bus.out_valid), 32'd0);
`ifdef ILLEGAL_OP_COUNT_EN
        check("cnt_fl", 32'(illegal_count), 32'd3);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
